// File: rtl/ram_read.sv
// ram_read: streams the frame RAM to an OLED byte sender, page by page with per-page address commands.
// Define RAM_READ_CONTINUOUS_EN for endless refresh; otherwise one frame per en_ram_rd request.
module ram_read #(
  parameter logic [7:0] COL_START = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_ram_rd,
  output logic [9:0] rdaddress,
  input  logic [7:0] q,
  output logic       tx_valid,
  output logic       tx_dc,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [2:0] {IDLE, CMD_PAGE, CMD_COLL, CMD_COLH, RD_ADDR, RD_WAIT, SEND, NEXT} state_t;
  state_t state, state_nx;
  logic [2:0] page;
  logic [6:0] col;
  logic [7:0] data;
  logic xfer;
  assign xfer = tx_valid && tx_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // Page 0 lives at the top of the RAM, so the page field of the address is inverted.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      page <= '0;
      col <= '0;
      rdaddress <= '0;
      data <= '0;
    end else begin
      if (state == IDLE && en_ram_rd) begin
        page <= '0;
        col <= '0;
      end
      if (state == RD_ADDR) rdaddress <= {3'd7 - page, col};
      if (state == RD_WAIT) data <= q;
      if (state == SEND && xfer) col <= col + 7'd1;
      if (state == NEXT) begin
        page <= page + 3'd1;
        col <= '0;
      end
    end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = en_ram_rd ? CMD_PAGE : IDLE;
      CMD_PAGE: state_nx = xfer ? CMD_COLL : CMD_PAGE;
      CMD_COLL: state_nx = xfer ? CMD_COLH : CMD_COLL;
      CMD_COLH: state_nx = xfer ? RD_ADDR : CMD_COLH;
      RD_ADDR:  state_nx = RD_WAIT;
      RD_WAIT:  state_nx = SEND;
      SEND:     state_nx = xfer ? (col == 7'd127 ? NEXT : RD_ADDR) : SEND;
`ifdef RAM_READ_CONTINUOUS_EN
      NEXT:     state_nx = CMD_PAGE;
`else
      NEXT:     state_nx = page == 3'd7 ? IDLE : CMD_PAGE;
`endif
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    tx_valid = state inside {CMD_PAGE, CMD_COLL, CMD_COLH, SEND};
    tx_dc = state == SEND;
    tx_data = state == CMD_PAGE ? {5'b10110, page} :
              state == CMD_COLL ? {4'h0, COL_START[3:0]} :
              state == CMD_COLH ? {4'h1, COL_START[7:4]} :
              state == SEND     ? data : 8'h00;
    busy = state != IDLE;
    frame_done = state == NEXT && page == 3'd7;
  end
endmodule

// File: tb/tb_ram_read.sv
// tb_ram_read: directed vector table plus frame-level stream checks for ram_read.
`timescale 1ns/1ps
module tb_ram_read;
  logic clk = 1'b0;
  logic rst, en_ram_rd, tx_ready;
  logic [9:0] ra0, ra1;
  logic [7:0] q0, q1, d0, d1;
  logic v0, v1, dc0, dc1, b0, b1, fd0, fd1;
  int errs = 0, checks = 0, fd_cnt = 0;
  logic [8:0] s0[$], s1[$];
  int m0, m1, mf, n, bad, first;
  typedef struct {
    logic en, rdy, v, dc;
    logic [7:0] d;
    logic busy;
    logic [9:0] a;
  } vec_t;
  vec_t vt[13];
  always #5 clk = ~clk;
  assign q0 = ra0[7:0];
  assign q1 = ra1[7:0];
  ram_read u0 (.clk(clk), .rst(rst), .en_ram_rd(en_ram_rd), .rdaddress(ra0), .q(q0),
    .tx_valid(v0), .tx_dc(dc0), .tx_data(d0), .tx_ready(tx_ready), .busy(b0), .frame_done(fd0));
  ram_read #(.COL_START(8'h02)) u1 (.clk(clk), .rst(rst), .en_ram_rd(en_ram_rd), .rdaddress(ra1), .q(q1),
    .tx_valid(v1), .tx_dc(dc1), .tx_data(d1), .tx_ready(tx_ready), .busy(b1), .frame_done(fd1));
  // Inputs only change just after rising edges, so a transfer seen here happens on the next edge.
  always @(negedge clk)
    if (!rst) begin
      if (v0 && tx_ready) s0.push_back({dc0, d0});
      if (v1 && tx_ready) s1.push_back({dc1, d1});
      if (fd0) fd_cnt++;
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [8:0] exp_byte(input int idx, input logic [7:0] cs);
    int p, k, a;
    p = idx / 131;
    k = idx % 131;
    a = (7 - p) * 128 + k - 3;
    if (k == 0) return {1'b0, 5'b10110, p[2:0]};
    if (k == 1) return {1'b0, 4'h0, cs[3:0]};
    if (k == 2) return {1'b0, 4'h1, cs[7:4]};
    return {1'b1, a[7:0]};
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    en_ram_rd = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic start();
    en_ram_rd = 1'b1;
    @(posedge clk);
    #1 en_ram_rd = 1'b0;
  endtask
  task automatic stream_chk(input string nm, input int which, input int base, input logic [7:0] cs);
    bad = 0;
    first = -1;
    for (int i = 0; i < 8 * 131; i++)
      if ((which == 0 ? s0[base + i] : s1[base + i]) !== exp_byte(i, cs)) begin
        bad++;
        if (first < 0) first = i;
      end
    if (bad != 0) $display("  %s: first bad byte index %0d", nm, first);
    chk(nm, bad, 0);
  endtask
  initial begin
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 10'd0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hB0, 1'b1, 10'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hB0, 1'b1, 10'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 10'd0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 10'd0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'd0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'd896};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 10'd896};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 10'd896};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'd896};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'd897};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 10'd897};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'd897};
    rst = 1'b1;
    en_ram_rd = 1'b0;
    tx_ready = 1'b1;
    #1;
    chk("reset_valid", v0, 0);
    chk("reset_busy", b0, 0);
    chk("reset_addr", ra0, 0);
    chk("reset_data", d0, 0);
    chk("reset_fd", fd0, 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      en_ram_rd = vt[i].en;
      tx_ready = vt[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), v0, vt[i].v);
      chk($sformatf("vec%0d_dc", i), dc0, vt[i].dc);
      chk($sformatf("vec%0d_data", i), d0, vt[i].d);
      chk($sformatf("vec%0d_busy", i), b0, vt[i].busy);
      chk($sformatf("vec%0d_addr", i), ra0, vt[i].a);
    end
    // Full frame with a 10-cycle stall on page 0 column 5.
    do_reset();
    m0 = s0.size();
    m1 = s1.size();
    mf = fd_cnt;
    start();
    n = 0;
    while (!(v0 && dc0 && ra0 == 10'd901) && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reach_col5", n < 100, 1);
    tx_ready = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("stall_valid", v0, 1);
      chk("stall_data", d0, 8'h85);
      chk("stall_addr", ra0, 10'd901);
    end
    tx_ready = 1'b1;
`ifdef RAM_READ_CONTINUOUS_EN
    n = 0;
    while (fd_cnt - mf < 1 && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("frame_done_seen", fd_cnt - mf, 1);
    n = 0;
    while (s0.size() <= m0 + 8 * 131 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("wrap_cmd", s0[m0 + 8 * 131], 9'h0B0);
    chk("wrap_busy", b0, 1);
    stream_chk("stream_col0", 0, m0, 8'h00);
    stream_chk("stream_col2", 1, m1, 8'h02);
    n = 0;
    while (fd_cnt - mf < 2 && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("frame_done_second", fd_cnt - mf, 2);
`else
    n = 0;
    while (b0 && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("frame_end_busy", b0, 0);
    chk("frame_count0", s0.size() - m0, 8 * 131);
    chk("frame_count1", s1.size() - m1, 8 * 131);
    chk("frame_done_once", fd_cnt - mf, 1);
    stream_chk("stream_col0", 0, m0, 8'h00);
    stream_chk("stream_col2", 1, m1, 8'h02);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_bytes", s0.size() - m0, 8 * 131);
    m0 = s0.size();
    start();
    n = 0;
    while (s0.size() <= m0 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("restart_b0", s0[m0], 9'h0B0);
`endif
    // Asynchronous reset in the middle of page 3 column 40.
    n = 0;
    while (!(v0 && dc0 && ra0 == 10'd552) && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reach_p3c40", n < 5000, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", v0, 0);
    chk("async_dc", dc0, 0);
    chk("async_data", d0, 0);
    chk("async_busy", b0, 0);
    chk("async_addr", ra0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m0 = s0.size();
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_quiet", s0.size() - m0, 0);
    chk("post_rst_busy", b0, 0);
    start();
    n = 0;
    while (s0.size() <= m0 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("rst_restart_b0", s0[m0], 9'h0B0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ram_read.md
RAM_READ -- requirements
Module: ram_read

Interface
REQ-001 Parameter COL_START, default 8'd0, OLED start column sent in the column-address commands of every page.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en_ram_rd  input  1  start request; a level sampled in IDLE.
REQ-005 rdaddress  output  10  frame-RAM read address.
REQ-006 q  input  8  frame-RAM read data, valid one clk after rdaddress changes.
REQ-007 tx_valid  output  1  byte offered to the OLED byte sender.
REQ-008 tx_dc  output  1  0 = command byte, 1 = display-data byte.
REQ-009 tx_data  output  8  byte offered.
REQ-010 tx_ready  input  1  sender accepts; a transfer occurs on an edge with tx_valid && tx_ready.
REQ-011 busy  output  1  high from leaving IDLE until returning to IDLE.
REQ-012 frame_done  output  1  one-clk pulse after the last byte of page 7 transfers.

Function
REQ-013 RAM map: OLED page p (0..7) occupies addresses (7-p)*128 .. (7-p)*128+127; column c is at base+c.
REQ-014 States: IDLE, CMD_PAGE, CMD_COLL, CMD_COLH, RD_ADDR, RD_WAIT, SEND, NEXT.
REQ-015 IDLE -> CMD_PAGE when en_ram_rd=1; page counter=0, column counter=0.
REQ-016 Command bytes, in order: CMD_PAGE 8'hB0+page; CMD_COLL {4'h0,COL_START[3:0]}; CMD_COLH {4'h1,COL_START[7:4]}; tx_dc=0 for all three.
REQ-017 Each command state holds tx_valid=1 with stable tx_data/tx_dc until a transfer, then advances; CMD_COLH advances to RD_ADDR.
REQ-018 RD_ADDR registers rdaddress=(7-page)*128+col; RD_WAIT waits one clk; on leaving RD_WAIT, q is captured into tx_data, and tx_dc=1, tx_valid=1 in SEND.
REQ-019 In SEND, tx_data is held until a transfer; then col increments; col≠127 -> RD_ADDR; col=127 -> NEXT.
REQ-020 NEXT: page<7 -> page+1, col=0, CMD_PAGE; page=7 -> frame_done pulse, then end-of-frame action per REQ-028/029.
REQ-021 tx_valid is never deasserted before a transfer; tx_valid=0 in IDLE, RD_ADDR, RD_WAIT, NEXT.
REQ-022 With tx_ready tied high: 3 clk per data byte, 1 clk per command byte; frame = 8*(3+128*3)+overhead clk.
REQ-023 en_ram_rd is ignored while busy=1.
REQ-024 Counters: col 7 bits, page 3 bits; the address arithmetic is 10 bits wide with no overflow.

Reset
REQ-025 While rst=1, immediately: state=IDLE, rdaddress=0, tx_valid=0, tx_dc=0, tx_data=0, busy=0, frame_done=0, counters=0.
REQ-026 Reset mid-frame abandons the frame; no byte is re-offered after release until a new start.
REQ-027 After rst is released, the first start request is honoured on the first edge where en_ram_rd=1.

Configuration
REQ-028 Macro RAM_READ_CONTINUOUS_EN defined: after page 7, go to CMD_PAGE with page=0 (endless refresh, busy stays 1); frame_done pulses once per frame.
REQ-029 Macro undefined: after page 7, go to IDLE (busy=0); a new frame needs en_ram_rd=1.

Verification
REQ-030 RAM preloaded so addr N holds N[7:0], tx_ready=1, pulse en_ram_rd -> first bytes B0,00,10 (dc=0); then data 0x80..0xFF (addresses 896..1023, dc=1); then B1.
REQ-031 COL_START=8'h02 -> each page sends B<p>,02,10 before its data.
REQ-032 tx_ready held low 10 clk during SEND of col 5 -> tx_valid/tx_data stable, rdaddress unchanged, no skipped or duplicated byte.
REQ-033 Full frame, macro undefined -> exactly 8*131 transfers, one frame_done pulse, busy=0; a second en_ram_rd restarts at B0.
REQ-034 rst=1 asserted during page 3 col 40 -> outputs reset asynchronously; after release with en_ram_rd=1 the frame restarts at B0.
REQ-035 Macro defined -> after the last byte of page 7 the next command is B0 with no en_ram_rd; frame_done pulses each frame.
